robo_mission_controller: RTL and testbench

Mission sequencer for the pipe-cleaning robot. It holds the robot in reset until a mission is started, loads the start pose and movement budget, and releases the robot. While the robot runs, it tracks row, column and orientation from the robot's `front`/`turn` outputs, and counts movements and trash removals. It halts the robot on budget exhaustion or on an attempted exit from the 10x20 map.

---
 rtl/robo_mission_controller.sv | 189 ++++++++++++++++++
 tb/tb_robo_mission_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/robo_mission_controller.sv
// Mission sequencer for the pipe-cleaning robot.
// It holds the robot in reset until a mission starts, then loads the start pose and the move budget.
// While the robot runs it tracks pose, moves and trash removals.
// It halts the robot when the budget is used up or when a move would leave the map.
module robo_mission_controller #(
  parameter int ROWS  = 10,
  parameter int COLS  = 20,
  parameter int CNT_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       init_row,
  input  logic [5:0]       init_col,
  input  logic [1:0]       init_orient,
  input  logic [CNT_W-1:0] max_moves,
  input  logic             front,
  input  logic             turn,
  input  logic             remove,
  output logic             robot_reset,
  output logic [5:0]       row,
  output logic [5:0]       col,
  output logic [1:0]       orient,
  output logic [CNT_W-1:0] moves_done,
  output logic [7:0]       trash_count,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam logic [5:0] ROW_MAX = 6'(ROWS);
  localparam logic [5:0] COL_MAX = 6'(COLS);

  localparam logic [1:0] NORTH = 2'b00;
  localparam logic [1:0] SOUTH = 2'b01;
  localparam logic [1:0] EAST  = 2'b10;
  localparam logic [1:0] WEST  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic [1:0]       orient_q, orient_d;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [7:0]       trash_q, trash_d;
  logic             robot_reset_q, robot_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic             pose_bad;
  logic             exit_map;
  logic [CNT_W-1:0] moves_inc;

  // Next-state, pose tracking and registered-output computation
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    orient_d = orient_q;
    moves_d  = moves_q;
    budget_d = budget_q;
    trash_d  = trash_q;
    done_d   = done_q;
    fault_d  = fault_q;

    pose_bad = (init_row == 6'd0) || (init_row > ROW_MAX) ||
               (init_col == 6'd0) || (init_col > COL_MAX);

    // A forward step from a border cell toward the outside leaves the map
    exit_map = front && (((orient_q == NORTH) && (row_q == 6'd1))    ||
                         ((orient_q == SOUTH) && (row_q == ROW_MAX)) ||
                         ((orient_q == EAST)  && (col_q == COL_MAX)) ||
                         ((orient_q == WEST)  && (col_q == 6'd1)));
    moves_inc = moves_q + 1'b1;

    case (state_q)
      IDLE, DONE, FAULT: begin
        if (start) begin
          if (pose_bad) begin
            // Reject the mission and leave the pose untouched
            state_d = FAULT;
            fault_d = 1'b1;
            done_d  = 1'b0;
          end else begin
            row_d    = init_row;
            col_d    = init_col;
            orient_d = init_orient;
            moves_d  = '0;
            trash_d  = '0;
            budget_d = max_moves;
            fault_d  = 1'b0;
            if (max_moves == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ARM;
              done_d  = 1'b0;
            end
          end
        end
      end
      ARM: state_d = RUN;
      RUN: begin
        if (exit_map) begin
          // Stop before the illegal step: pose and counters stay as they are
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          if (front) begin
            case (orient_q)
              NORTH:   row_d = row_q - 6'd1;
              SOUTH:   row_d = row_q + 6'd1;
              EAST:    col_d = col_q + 6'd1;
              default: col_d = col_q - 6'd1;
            endcase
          end else if (turn) begin
            case (orient_q)
              NORTH:   orient_d = WEST;
              WEST:    orient_d = SOUTH;
              SOUTH:   orient_d = EAST;
              default: orient_d = NORTH;
            endcase
          end
          if (remove && (trash_q != 8'hFF)) begin
            trash_d = trash_q + 8'd1;
          end
          moves_d = moves_inc;
          if (moves_inc == budget_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d        = (state_d == ARM) || (state_d == RUN);
    robot_reset_d = (state_d != RUN);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      orient_q      <= '0;
      moves_q       <= '0;
      budget_q      <= '0;
      trash_q       <= '0;
      robot_reset_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      orient_q      <= orient_d;
      moves_q       <= moves_d;
      budget_q      <= budget_d;
      trash_q       <= trash_d;
      robot_reset_q <= robot_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign robot_reset = robot_reset_q;
  assign row         = row_q;
  assign col         = col_q;
  assign orient      = orient_q;
  assign moves_done  = moves_q;
  assign trash_count = trash_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_robo_mission_controller.sv
// Directed testbench for robo_mission_controller with hand-computed expectations.
module tb_robo_mission_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] init_row = '0;
  logic [5:0] init_col = '0;
  logic [1:0] init_orient = '0;
  logic [8:0] max_moves = '0;
  logic       front = 1'b0;
  logic       turn = 1'b0;
  logic       remove = 1'b0;
  logic       robot_reset;
  logic [5:0] row;
  logic [5:0] col;
  logic [1:0] orient;
  logic [8:0] moves_done;
  logic [7:0] trash_count;
  logic       busy;
  logic       done;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  robo_mission_controller #(.ROWS(10), .COLS(20), .CNT_W(9)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .init_row    (init_row),
    .init_col    (init_col),
    .init_orient (init_orient),
    .max_moves   (max_moves),
    .front       (front),
    .turn        (turn),
    .remove      (remove),
    .robot_reset (robot_reset),
    .row         (row),
    .col         (col),
    .orient      (orient),
    .moves_done  (moves_done),
    .trash_count (trash_count),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a start on the next edge; returns after the edge
  task automatic do_start(input logic [5:0] r, input logic [5:0] c,
                          input logic [1:0] o, input logic [8:0] m);
    init_row = r; init_col = c; init_orient = o; max_moves = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset with start held: must stay idle
    init_row = 6'd5; init_col = 6'd5; max_moves = 9'd3; start = 1'b1;
    tick(); tick();
    check("rst_robot_reset", robot_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_row", row, 0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_robot_reset", robot_reset, 1);
    check("idle_done", done, 0);
    check("idle_fault", fault, 0);

    // Forward run north
    front = 1'b1;
    do_start(6'd5, 6'd5, 2'b00, 9'd3);
    check("fwd_arm_busy", busy, 1);
    check("fwd_arm_robot_reset", robot_reset, 1);
    tick();
    check("fwd_run_robot_reset", robot_reset, 0);
    check("fwd_run_row", row, 5);
    tick(); check("fwd_row_m1", row, 4);
    tick(); check("fwd_row_m2", row, 3);
    tick(); check("fwd_row_m3", row, 2);
    check("fwd_moves", moves_done, 3);
    check("fwd_done", done, 1);
    check("fwd_busy", busy, 0);
    check("fwd_robot_reset", robot_reset, 1);
    front = 1'b0;

    // Rotation only
    turn = 1'b1;
    do_start(6'd5, 6'd5, 2'b00, 9'd4);
    check("rot_done_cleared", done, 0);
    tick();
    tick(); check("rot_o1", orient, 2'b11);
    tick(); check("rot_o2", orient, 2'b01);
    tick(); check("rot_o3", orient, 2'b10);
    tick(); check("rot_o4", orient, 2'b00);
    check("rot_row", row, 5);
    check("rot_col", col, 5);
    check("rot_done", done, 1);

    // Front and turn together: move wins
    front = 1'b1;
    do_start(6'd5, 6'd5, 2'b00, 9'd1);
    tick(); tick();
    check("prio_row", row, 4);
    check("prio_orient", orient, 2'b00);
    check("prio_done", done, 1);
    front = 1'b0; turn = 1'b0;

    // Exit north from row 1
    front = 1'b1;
    do_start(6'd1, 6'd3, 2'b00, 9'd5);
    tick(); tick();
    check("exitn_fault", fault, 1);
    check("exitn_row", row, 1);
    check("exitn_moves", moves_done, 0);
    check("exitn_robot_reset", robot_reset, 1);
    check("exitn_done", done, 0);

    // Exit east from column 20 after one legal step from column 19
    do_start(6'd4, 6'd19, 2'b10, 9'd5);
    check("exite_fault_cleared", fault, 0);
    tick(); tick();
    check("exite_col_m1", col, 20);
    tick();
    check("exite_fault", fault, 1);
    check("exite_col", col, 20);
    check("exite_moves", moves_done, 1);
    front = 1'b0;

    // Zero budget: done immediately, robot never released
    do_start(6'd7, 6'd8, 2'b01, 9'd0);
    check("zero_done", done, 1);
    check("zero_fault", fault, 0);
    check("zero_row", row, 7);
    check("zero_robot_reset", robot_reset, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_robot_reset_hold", robot_reset, 1);

    // Invalid column: fault, pose not loaded
    do_start(6'd3, 6'd21, 2'b00, 9'd5);
    check("badc_fault", fault, 1);
    check("badc_done", done, 0);
    check("badc_col", col, 8);
    check("badc_robot_reset", robot_reset, 1);
    tick();
    check("badc_robot_reset_hold", robot_reset, 1);

    // Invalid row 0
    do_start(6'd0, 6'd4, 2'b00, 9'd5);
    check("badr_fault", fault, 1);
    check("badr_row", row, 7);
    check("badr_robot_reset", robot_reset, 1);

    // Trash on movements 2 and 3
    do_start(6'd5, 6'd5, 2'b10, 9'd4);
    tick();
    remove = 1'b0; tick();
    remove = 1'b1; tick();
    tick();
    remove = 1'b0; tick();
    check("trash_count", trash_count, 2);
    check("trash_moves", moves_done, 4);
    check("trash_done", done, 1);

    // Start and budget change during RUN are ignored
    do_start(6'd5, 6'd5, 2'b10, 9'd3);
    tick();
    tick();
    init_row = 6'd2; max_moves = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_row", row, 5);
    check("ign_moves", moves_done, 2);
    check("ign_busy", busy, 1);
    tick();
    check("ign_done", done, 1);
    check("ign_moves_end", moves_done, 3);

    // Asynchronous reset mid-RUN
    do_start(6'd5, 6'd5, 2'b00, 9'd10);
    tick(); tick(); tick();
    check("abort_pre_robot_reset", robot_reset, 0);
    #2 reset = 1'b1;
    #1;
    check("abort_robot_reset", robot_reset, 1);
    check("abort_busy", busy, 0);
    check("abort_row", row, 0);
    check("abort_moves", moves_done, 0);
    tick();
    reset = 1'b0;
    tick();
    check("abort_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
